// File: rtl/wb_conbus_rr.sv
// Shared-bus Wishbone interconnect with round-robin arbitration.
// It routes ack/err back to the owning master, returns an error for
// unmapped addresses and uses an ack timeout so a stalled slave cannot hang
// the bus.
module wb_conbus_rr #(
  parameter int NUM_M    = 4,
  parameter int NUM_S    = 8,
  parameter int ADDR_W   = 14,
  parameter int DATA_W   = 16,
  parameter int S_ADDR_W = 4,
  parameter logic [NUM_S*S_ADDR_W-1:0] S_BASE = {8'hEC, 8'hA8, 8'h64, 8'h20},
  parameter int TIMEOUT  = 255,
  localparam int SEL_W   = DATA_W/8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_M*ADDR_W-1:0]  m_adr_i,
  input  logic [NUM_M*DATA_W-1:0]  m_dat_i,
  input  logic [NUM_M*SEL_W-1:0]   m_sel_i,
  input  logic [NUM_M-1:0]         m_we_i,
  input  logic [NUM_M-1:0]         m_cyc_i,
  input  logic [NUM_M-1:0]         m_stb_i,
  output logic [DATA_W-1:0]        m_dat_o,
  output logic [NUM_M-1:0]         m_ack_o,
  output logic [NUM_M-1:0]         m_err_o,
  output logic [ADDR_W-1:0]        s_adr_o,
  output logic [DATA_W-1:0]        s_dat_o,
  output logic [SEL_W-1:0]         s_sel_o,
  output logic                     s_we_o,
  output logic [NUM_S-1:0]         s_cyc_o,
  output logic [NUM_S-1:0]         s_stb_o,
  input  logic [NUM_S*DATA_W-1:0]  s_dat_i,
  input  logic [NUM_S-1:0]         s_ack_i,
  output logic [NUM_M-1:0]         grant_o,
  output logic                     busy_o
);

  localparam int MW = (NUM_M > 1) ? $clog2(NUM_M) : 1;
  localparam int SW = (NUM_S > 1) ? $clog2(NUM_S) : 1;
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic {IDLE, OWNED} state_t;

  state_t            state, state_nx;
  logic [NUM_M-1:0]  grant, grant_nx;
  logic [MW-1:0]     owner, owner_nx, last, last_nx;
  logic [CW-1:0]     cnt;
  logic              unm_q;

  logic [ADDR_W-1:0] o_adr;
  logic [DATA_W-1:0] o_dat;
  logic [SEL_W-1:0]  o_sel;
  logic              o_we, o_cyc, o_stb, stb_act;
  logic              mapped, sel_ok, ack_sel, to_hit, err_now, found;
  logic [SW-1:0]     sel;
  int                idx;

  // Arbiter state, owner and last-owner pointer registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      grant <= '0;
      owner <= '0;
      last  <= MW'(NUM_M - 1);
    end else begin
      state <= state_nx;
      grant <= grant_nx;
      owner <= owner_nx;
      last  <= last_nx;
    end
  end

  // Round-robin pick in IDLE; release when the owner drops cyc
  always_comb begin
    state_nx = state;
    grant_nx = grant;
    owner_nx = owner;
    last_nx  = last;
    found    = 1'b0;
    idx      = 0;
    case (state)
      IDLE: begin
        if (|m_cyc_i) begin
          for (int i = 1; i <= NUM_M; i++) begin
            idx = int'(last) + i;
            if (idx >= NUM_M) idx = idx - NUM_M;
            if (!found && m_cyc_i[idx]) begin
              found           = 1'b1;
              owner_nx        = MW'(idx);
              grant_nx        = '0;
              grant_nx[idx]   = 1'b1;
            end
          end
          state_nx = OWNED;
        end
      end
      OWNED: begin
        if (!o_cyc) begin
          state_nx = IDLE;
          grant_nx = '0;
          last_nx  = owner;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Owner's request signals; all zero while idle
  always_comb begin
    o_adr = '0;
    o_dat = '0;
    o_sel = '0;
    o_we  = 1'b0;
    o_cyc = 1'b0;
    o_stb = 1'b0;
    if (state == OWNED) begin
      o_adr = m_adr_i[int'(owner)*ADDR_W +: ADDR_W];
      o_dat = m_dat_i[int'(owner)*DATA_W +: DATA_W];
      o_sel = m_sel_i[int'(owner)*SEL_W +: SEL_W];
      o_we  = m_we_i[owner];
      o_cyc = m_cyc_i[owner];
      o_stb = m_stb_i[owner];
    end
  end

  // Address decode; scanning downward leaves the lowest matching slave
  always_comb begin
    mapped = 1'b0;
    sel    = '0;
    for (int k = NUM_S - 1; k >= 0; k--) begin
      if (o_adr[ADDR_W-1 -: S_ADDR_W] == S_BASE[k*S_ADDR_W +: S_ADDR_W]) begin
        mapped = 1'b1;
        sel    = SW'(k);
      end
    end
  end

  assign stb_act = o_cyc & o_stb;
  assign sel_ok  = o_cyc & mapped;
  assign ack_sel = sel_ok & s_ack_i[sel];
  // An ack in the expiry cycle wins, so the timeout only fires without ack
  assign to_hit  = (TIMEOUT != 0) && stb_act && !ack_sel &&
                   (cnt == CW'(TIMEOUT - 1));
  assign err_now = (state == OWNED) && (unm_q || to_hit) && !ack_sel;

  // Ack timeout counter: clears on ack, idle stb, expiry or owner change
  always_ff @(posedge clk) begin
    if (rst || state != OWNED || !stb_act || ack_sel || to_hit)
      cnt <= '0;
    else if (cnt != CW'(TIMEOUT))
      cnt <= cnt + CW'(1);
  end

  // Unmapped-address error, one cycle after the strobe is seen
  always_ff @(posedge clk) begin
    if (rst) unm_q <= 1'b0;
    else     unm_q <= (state == OWNED) && stb_act && !mapped && !unm_q;
  end

  // Slave-side strobes; stb is withheld in the cycle the timeout fires
  always_comb begin
    s_cyc_o = '0;
    s_stb_o = '0;
    if (sel_ok) begin
      s_cyc_o[sel] = 1'b1;
      s_stb_o[sel] = o_stb & ~to_hit;
    end
  end

  assign s_adr_o = o_adr;
  assign s_dat_o = o_dat;
  assign s_sel_o = o_sel;
  assign s_we_o  = o_we;
  assign m_dat_o = sel_ok ? s_dat_i[int'(sel)*DATA_W +: DATA_W] : '0;
  assign m_ack_o = ack_sel ? grant : '0;
  assign m_err_o = err_now ? grant : '0;
  assign grant_o = grant;
  assign busy_o  = (state == OWNED);

endmodule

// File: tb/tb_wb_conbus_rr.sv
// Scoreboard bench for wb_conbus_rr: 4 masters, 8 slaves, slave 3 unmapped
// (base 6 replaced by a duplicate 0) and an 8-cycle ack timeout.
module tb_wb_conbus_rr;
  localparam int NM = 4, NS = 8, AW = 14, DW = 16, SW = 2;

  typedef struct { int m; logic [DW-1:0] dat; bit err; } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [NM*AW-1:0] m_adr;
  logic [NM*DW-1:0] m_dat;
  logic [NM*SW-1:0] m_sel;
  logic [NM-1:0]    m_we, m_cyc, m_stb;
  logic [DW-1:0]    m_dat_o;
  logic [NM-1:0]    m_ack_o, m_err_o, grant_o;
  logic [AW-1:0]    s_adr_o;
  logic [DW-1:0]    s_dat_o;
  logic [SW-1:0]    s_sel_o;
  logic             s_we_o, busy_o;
  logic [NS-1:0]    s_cyc_o, s_stb_o, s_ack, ack_mask;
  logic [NS*DW-1:0] s_dat;

  // Slaves ack from cyc (not stb) whenever the bench enables them
  assign s_ack = s_cyc_o & ack_mask;

  wb_conbus_rr #(.NUM_M(NM), .NUM_S(NS), .ADDR_W(AW), .DATA_W(DW), .S_ADDR_W(4),
                 .S_BASE(32'hECA8_0420), .TIMEOUT(8)) dut (
    .clk(clk), .rst(rst),
    .m_adr_i(m_adr), .m_dat_i(m_dat), .m_sel_i(m_sel), .m_we_i(m_we),
    .m_cyc_i(m_cyc), .m_stb_i(m_stb), .m_dat_o(m_dat_o), .m_ack_o(m_ack_o),
    .m_err_o(m_err_o), .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o),
    .s_we_o(s_we_o), .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_dat_i(s_dat),
    .s_ack_i(s_ack), .grant_o(grant_o), .busy_o(busy_o));

  int   n_cmp = 0, n_bad = 0;
  exp_t sb[$];

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic mdrive(input int i, input logic [AW-1:0] a, input logic we,
                        input logic [DW-1:0] d, input logic c);
    m_adr[i*AW +: AW] = a;
    m_dat[i*DW +: DW] = d;
    m_sel[i*SW +: SW] = 2'b11;
    m_we[i]  = we;
    m_cyc[i] = c;
    m_stb[i] = c;
  endtask

  task automatic test_reset();
    rst = 1'b1; m_adr = '0; m_dat = '0; m_sel = '0; m_we = '0; m_cyc = '0; m_stb = '0;
    ack_mask = '0;
    for (int k = 0; k < NS; k++) s_dat[k*DW +: DW] = 16'hD000 | 16'(k);
    tick(); tick();
    @(negedge clk);
    n_cmp++;
    if ({grant_o, busy_o, s_cyc_o, s_stb_o, m_ack_o, m_err_o} !== '0) begin
      n_bad++;
      $display("FAIL reset_outputs got g=%b b=%b cyc=%b stb=%b ack=%b err=%b want all 0",
               grant_o, busy_o, s_cyc_o, s_stb_o, m_ack_o, m_err_o);
    end
    tick(); rst = 1'b0;
  endtask

  task automatic test_fairness();
    logic [NM-1:0] gq[$];
    logic [NM-1:0] prev, acked, eg, oh;
    int rem[NM], st[NM], cyc;
    exp_t e;
    gq  = '{4'b0001, 4'b0010, 4'b1000, 4'b0001};
    rem = '{2, 1, 0, 1};
    st  = '{0, 0, 0, 0};
    tick();
    ack_mask = '1;
    for (int i = 0; i < NM; i++)
      if (rem[i] > 0) begin mdrive(i, AW'(i), 1'b0, '0, 1'b1); st[i] = 1; end
    sb.push_back('{0, 16'hD000, 1'b0}); sb.push_back('{1, 16'hD000, 1'b0});
    sb.push_back('{3, 16'hD000, 1'b0}); sb.push_back('{0, 16'hD000, 1'b0});
    prev = '0; cyc = 0;
    while ((gq.size() > 0 || sb.size() > 0) && cyc < 60) begin
      @(negedge clk);
      if (grant_o !== prev) begin
        n_cmp++;
        if (prev != 0 && grant_o != 0) begin
          n_bad++; $display("FAIL fair_idle_gap got %b after %b want 0000 between", grant_o, prev);
        end
      end
      if (prev == 0 && grant_o != 0) begin
        n_cmp++;
        eg = (gq.size() > 0) ? gq.pop_front() : '0;
        if (grant_o !== eg) begin
          n_bad++; $display("FAIL fair_grant_order got %b want %b", grant_o, eg);
        end
      end
      acked = m_ack_o;
      if (m_ack_o != 0 || m_err_o != 0) begin
        n_cmp++;
        e = (sb.size() > 0) ? sb.pop_front() : '{-1, '0, 1'b1};
        oh = (e.m >= 0) ? (NM'(1) << e.m) : '0;
        if ({m_ack_o, m_err_o, m_dat_o} !== {oh, 4'b0000, e.dat} || m_ack_o !== grant_o) begin
          n_bad++;
          $display("FAIL fair_resp got ack=%b err=%b dat=%h grant=%b want ack=%b err=0000 dat=%h",
                   m_ack_o, m_err_o, m_dat_o, grant_o, oh, e.dat);
        end
      end
      prev = grant_o;
      tick(); cyc++;
      for (int i = 0; i < NM; i++) begin
        if (acked[i]) begin
          mdrive(i, AW'(i), 1'b0, '0, 1'b0); rem[i]--; st[i] = (rem[i] > 0) ? 2 : 0;
        end else if (st[i] == 2) begin
          mdrive(i, AW'(i), 1'b0, '0, 1'b1); st[i] = 1;
        end
      end
    end
    n_cmp++;
    if (gq.size() != 0 || sb.size() != 0) begin
      n_bad++; $display("FAIL fair_budget got %0d grants / %0d acks outstanding want 0", gq.size(), sb.size());
    end
    sb.delete();
    m_cyc = '0; m_stb = '0; ack_mask = '0;
    tick(); tick();
  endtask

  task automatic test_single_write();
    exp_t e;
    logic [NM-1:0] oh;
    tick();
    mdrive(0, 14'h2805, 1'b1, 16'hBEEF, 1'b1);
    ack_mask = 8'h20;
    sb.push_back('{0, 16'hD005, 1'b0});
    @(negedge clk);
    n_cmp++;
    if ({grant_o, s_cyc_o} !== '0) begin
      n_bad++; $display("FAIL wr_latency got grant=%b cyc=%b want 0 in request cycle", grant_o, s_cyc_o);
    end
    tick(); @(negedge clk);
    n_cmp++;
    if ({grant_o, s_cyc_o, s_stb_o, s_adr_o, s_dat_o, s_we_o, s_sel_o} !==
        {4'b0001, 8'h20, 8'h20, 14'h2805, 16'hBEEF, 1'b1, 2'b11}) begin
      n_bad++;
      $display("FAIL wr_slave_side got g=%b cyc=%h stb=%h adr=%h dat=%h we=%b sel=%b want 0001 20 20 2805 beef 1 11",
               grant_o, s_cyc_o, s_stb_o, s_adr_o, s_dat_o, s_we_o, s_sel_o);
    end
    n_cmp++;
    e = (sb.size() > 0) ? sb.pop_front() : '{0, '0, 1'b1};
    oh = NM'(1) << e.m;
    if ({m_ack_o, m_err_o, m_dat_o} !== {oh, 4'b0000, e.dat}) begin
      n_bad++; $display("FAIL wr_ack got ack=%b err=%b dat=%h want ack=%b err=0000 dat=%h",
                        m_ack_o, m_err_o, m_dat_o, oh, e.dat);
    end
    tick();
    mdrive(0, 14'h2805, 1'b1, 16'hBEEF, 1'b0); ack_mask = '0;
    @(negedge clk);
    n_cmp++;
    if ({grant_o, s_cyc_o, m_ack_o} !== {4'b0001, 8'h00, 4'b0000}) begin
      n_bad++; $display("FAIL wr_release got g=%b cyc=%h ack=%b want 0001 00 0000", grant_o, s_cyc_o, m_ack_o);
    end
    tick(); @(negedge clk);
    n_cmp++;
    if ({grant_o, busy_o} !== 5'b0) begin
      n_bad++; $display("FAIL wr_idle got g=%b busy=%b want 0000 0", grant_o, busy_o);
    end
  endtask

  task automatic test_unmapped();
    exp_t e;
    tick();
    mdrive(2, 14'h1800, 1'b0, '0, 1'b1);
    ack_mask = '1;
    sb.push_back('{2, 16'h0000, 1'b1});
    tick(); @(negedge clk);
    n_cmp++;
    if ({grant_o, s_cyc_o, s_stb_o, m_ack_o, m_err_o} !== {4'b0100, 8'h00, 8'h00, 4'b0000, 4'b0000}) begin
      n_bad++; $display("FAIL unm_first got g=%b cyc=%h stb=%h ack=%b err=%b want 0100 00 00 0000 0000",
                        grant_o, s_cyc_o, s_stb_o, m_ack_o, m_err_o);
    end
    tick(); @(negedge clk);
    n_cmp++;
    e = (sb.size() > 0) ? sb.pop_front() : '{0, '0, 1'b0};
    if ({m_ack_o, m_err_o, m_dat_o, s_cyc_o} !== {4'b0000, NM'(1) << e.m, e.dat, 8'h00}) begin
      n_bad++; $display("FAIL unm_err got ack=%b err=%b dat=%h cyc=%h want 0000 0100 0000 00",
                        m_ack_o, m_err_o, m_dat_o, s_cyc_o);
    end
    tick();
    mdrive(2, 14'h1800, 1'b0, '0, 1'b0); ack_mask = '0;
    @(negedge clk);
    n_cmp++;
    if ({m_ack_o, m_err_o} !== 8'h00) begin
      n_bad++; $display("FAIL unm_pulse_width got ack=%b err=%b want 0000 0000", m_ack_o, m_err_o);
    end
    tick(); tick();
  endtask

  task automatic test_ack_wins();
    exp_t e;
    tick();
    mdrive(1, 14'h0800, 1'b0, '0, 1'b1);
    ack_mask = '0;
    sb.push_back('{1, 16'hD001, 1'b0});
    for (int c = 1; c <= 8; c++) begin
      tick();
      if (c == 8) ack_mask = 8'h02;
      @(negedge clk);
      n_cmp++;
      if (c < 8) begin
        if ({grant_o, s_stb_o, m_ack_o, m_err_o} !== {4'b0010, 8'h02, 4'b0000, 4'b0000}) begin
          n_bad++; $display("FAIL aw_wait c=%0d got g=%b stb=%h ack=%b err=%b want 0010 02 0000 0000",
                            c, grant_o, s_stb_o, m_ack_o, m_err_o);
        end
      end else begin
        e = (sb.size() > 0) ? sb.pop_front() : '{0, '0, 1'b1};
        if ({m_ack_o, m_err_o, m_dat_o, s_stb_o} !== {NM'(1) << e.m, 4'b0000, e.dat, 8'h02}) begin
          n_bad++; $display("FAIL aw_ack_wins got ack=%b err=%b dat=%h stb=%h want 0010 0000 d001 02",
                            m_ack_o, m_err_o, m_dat_o, s_stb_o);
        end
      end
    end
    tick();
    mdrive(1, 14'h0800, 1'b0, '0, 1'b0); ack_mask = '0;
    tick(); tick();
  endtask

  task automatic test_timeout();
    exp_t e;
    logic exp_hit;
    tick();
    mdrive(0, 14'h0010, 1'b0, '0, 1'b1);
    ack_mask = '0;
    sb.push_back('{0, 16'hD000, 1'b1}); sb.push_back('{0, 16'hD000, 1'b1});
    for (int c = 1; c <= 16; c++) begin
      tick(); @(negedge clk);
      exp_hit = (c == 8) || (c == 16);
      n_cmp++;
      if ({s_cyc_o, s_stb_o, m_ack_o, m_err_o} !==
          {8'h01, exp_hit ? 8'h00 : 8'h01, 4'b0000, exp_hit ? 4'b0001 : 4'b0000}) begin
        n_bad++; $display("FAIL to_cycle c=%0d got cyc=%h stb=%h ack=%b err=%b want err=%b",
                          c, s_cyc_o, s_stb_o, m_ack_o, m_err_o, exp_hit);
      end
      if (m_err_o != 0) begin
        n_cmp++;
        e = (sb.size() > 0) ? sb.pop_front() : '{0, '1, 1'b0};
        if ({m_err_o, m_dat_o} !== {NM'(1) << e.m, e.dat}) begin
          n_bad++; $display("FAIL to_err got err=%b dat=%h want 0001 d000", m_err_o, m_dat_o);
        end
      end
    end
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++; $display("FAIL to_missing got %0d errs outstanding want 0", sb.size());
    end
    sb.delete();
    tick();
    mdrive(0, 14'h0010, 1'b0, '0, 1'b0);
    tick(); tick();
  endtask

  task automatic test_reset_mid();
    tick();
    mdrive(1, 14'h1000, 1'b0, '0, 1'b1);
    ack_mask = '0;
    tick(); tick(); @(negedge clk);
    n_cmp++;
    if ({grant_o, busy_o, s_cyc_o} !== {4'b0010, 1'b1, 8'h04}) begin
      n_bad++; $display("FAIL rm_owned got g=%b busy=%b cyc=%h want 0010 1 04", grant_o, busy_o, s_cyc_o);
    end
    tick(); rst = 1'b1;
    tick(); rst = 1'b0;
    mdrive(0, 14'h0000, 1'b0, '0, 1'b1);
    @(negedge clk);
    n_cmp++;
    if ({grant_o, busy_o, s_cyc_o, s_stb_o, m_ack_o, m_err_o} !== '0) begin
      n_bad++; $display("FAIL rm_cleared got g=%b busy=%b cyc=%h stb=%h ack=%b err=%b want all 0",
                        grant_o, busy_o, s_cyc_o, s_stb_o, m_ack_o, m_err_o);
    end
    tick(); @(negedge clk);
    n_cmp++;
    if (grant_o !== 4'b0001) begin
      n_bad++; $display("FAIL rm_first_prio got g=%b want 0001", grant_o);
    end
    tick();
    m_cyc = '0; m_stb = '0;
    tick(); tick();
  endtask

  initial begin
    test_reset();
    test_fairness();
    test_single_write();
    test_unmapped();
    test_ack_wins();
    test_timeout();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got no finish want finish before 200000");
    $fatal(1);
  end
endmodule
